mem_stage_ctrl: RTL and testbench

- Parametrised successor to the single-cycle MEM stage: resolves branch, issues loads and stores to a variable-latency data memory over a req/ack handshake, and registers results into MEM/WB.
- Adds byte, half-word and word access with byte enables, load sign/zero extension, pipeline back-pressure while memory is busy, and a watchdog timeout.
- Sits between EX/MEM and MEM/WB; the data memory sits outside the stage.

---
 rtl/mem_stage_ctrl_if.sv | 49 ++++
 rtl/mem_stage_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_mem_stage_ctrl.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_ctrl_if.sv
// MEM stage bundle: EX/MEM entry, data-memory req/ack port and MEM/WB result.
// Latency: none, wiring only.
// Backpressure: in_ready from the stage stalls EX/MEM; dmem_ack paces each memory access.
interface mem_stage_ctrl_if #(
  parameter int XLEN = 32
);
  // EX/MEM side
  logic              in_valid;
  logic              in_ready;
  logic              mem_read;
  logic              mem_write;
  logic              branch;
  logic              zero;
  logic [2:0]        funct3;
  logic [XLEN-1:0]   result;
  logic [XLEN-1:0]   wd;
  logic              branch_taken;
  // data memory side
  logic              dmem_req;
  logic              dmem_we;
  logic [XLEN-1:0]   dmem_addr;
  logic [XLEN-1:0]   dmem_wdata;
  logic [XLEN/8-1:0] dmem_be;
  logic              dmem_ack;
  logic [XLEN-1:0]   dmem_rdata;
  // MEM/WB side
  logic              out_valid;
  logic [XLEN-1:0]   out_rdata;
  logic [XLEN-1:0]   out_result;
  logic              err;

  // Environment: EX/MEM producer, data memory and MEM/WB consumer.
  modport master (
    output in_valid, mem_read, mem_write, branch, zero, funct3, result, wd,
    output dmem_ack, dmem_rdata,
    input  in_ready, branch_taken,
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    input  out_valid, out_rdata, out_result, err
  );

  // The MEM stage itself.
  modport slave (
    input  in_valid, mem_read, mem_write, branch, zero, funct3, result, wd,
    input  dmem_ack, dmem_rdata,
    output in_ready, branch_taken,
    output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    output out_valid, out_rdata, out_result, err
  );
endinterface

// File: rtl/mem_stage_ctrl.sv
// MEM stage: branch resolve, B/H/W(/D) loads and stores over dmem req/ack, watchdog, MEM/WB register.
// Latency: non-memory entry 1 cycle to out_valid; memory entry out_valid 2 cycles after the ack cycle (min 3).
// Backpressure: in_ready is low from accept until the entry leaves DONE. Optional MEM_STAGE_MISALIGN_EN rejects misaligned accesses.
module mem_stage_ctrl #(
  parameter int XLEN    = 32,   // 32 or 64
  parameter int TIMEOUT = 255,  // cycles waiting for dmem_ack; 0 disables the watchdog
  parameter int CNT_W   = 8     // 2**CNT_W must exceed TIMEOUT
) (
  input  logic            clk,
  input  logic            rst_n,
  mem_stage_ctrl_if.slave bus
);

  localparam int NB    = XLEN / 8;
  localparam int OFF_W = $clog2(NB);
  // Watchdog fires on the cycle the counter would reach TIMEOUT.
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t            r_state;
  state_t            w_state_nxt;

  // Access attributes latched at accept, used when the ack returns.
  logic [1:0]        r_size;
  logic              r_uns;
  logic              r_is_load;
  logic [OFF_W-1:0]  r_off;
  logic [CNT_W-1:0]  r_cnt;

  logic              r_dmem_req;
  logic              r_dmem_we;
  logic [XLEN-1:0]   r_dmem_addr;
  logic [XLEN-1:0]   r_dmem_wdata;
  logic [NB-1:0]     r_dmem_be;
  logic              r_out_valid;
  logic [XLEN-1:0]   r_out_rdata;
  logic [XLEN-1:0]   r_out_result;
  logic              r_err;

  logic              w_is_mem;
  logic              w_is_load;
  logic [1:0]        w_size;
  logic [OFF_W-1:0]  w_off_raw;
  logic [OFF_W-1:0]  w_low;
  logic [OFF_W-1:0]  w_off;
  logic [NB-1:0]     w_be_base;
  logic [NB-1:0]     w_be;
  logic [XLEN-1:0]   w_wdata;
  logic [XLEN-1:0]   w_addr;
  logic [XLEN-1:0]   w_lane;
  logic [XLEN-1:0]   w_keep;
  logic              w_sbit;
  logic [XLEN-1:0]   w_ld;
  logic              w_timeout;

  assign w_is_mem  = bus.mem_read | bus.mem_write;
  // Read and write together is handled as a store.
  assign w_is_load = bus.mem_read & ~bus.mem_write;
  // A doubleword request on a 32-bit stage degrades to a word.
  assign w_size    = (XLEN == 32 && bus.funct3[1:0] == 2'd3) ? 2'd2 : bus.funct3[1:0];
  assign w_off_raw = bus.result[OFF_W-1:0];
  // Offset bits below the natural alignment of the access size.
  assign w_low     = OFF_W'((1 << w_size) - 1);
  assign w_off     = w_off_raw & ~w_low;
  assign w_be      = w_be_base << w_off;
  assign w_wdata   = bus.wd << {w_off, 3'b000};
  assign w_addr    = {bus.result[XLEN-1:OFF_W], {OFF_W{1'b0}}};
  assign w_lane    = bus.dmem_rdata >> {r_off, 3'b000};
  assign w_timeout = (TIMEOUT != 0) && (r_cnt == TO_LAST);

`ifdef MEM_STAGE_MISALIGN_EN
  logic w_misalign;
  assign w_misalign = |(w_off_raw & w_low);
`endif

  assign bus.in_ready     = (r_state == IDLE);
  assign bus.branch_taken = bus.in_valid & bus.branch & bus.zero;
  assign bus.dmem_req     = r_dmem_req;
  assign bus.dmem_we      = r_dmem_we;
  assign bus.dmem_addr    = r_dmem_addr;
  assign bus.dmem_wdata   = r_dmem_wdata;
  assign bus.dmem_be      = r_dmem_be;
  assign bus.out_valid    = r_out_valid;
  assign bus.out_rdata    = r_out_rdata;
  assign bus.out_result   = r_out_result;
  assign bus.err          = r_err;

  // Byte-enable pattern for the access size before lane shifting.
  always_comb begin
    w_be_base = '1;
    case (w_size)
      2'd0:    w_be_base = NB'(1);
      2'd1:    w_be_base = NB'(3);
      2'd2:    w_be_base = NB'(15);
      default: w_be_base = '1;
    endcase
  end

  // Load lane mask, sign bit and sign/zero extension of the returned word.
  always_comb begin
    w_keep = '1;
    w_sbit = w_lane[XLEN-1];
    case (r_size)
      2'd0:    begin w_keep = XLEN'(8'hFF);         w_sbit = w_lane[7];  end
      2'd1:    begin w_keep = XLEN'(16'hFFFF);      w_sbit = w_lane[15]; end
      2'd2:    begin w_keep = XLEN'(32'hFFFF_FFFF); w_sbit = w_lane[31]; end
      default: begin w_keep = '1;                   w_sbit = w_lane[XLEN-1]; end
    endcase
    w_ld = (w_lane & w_keep) | ((!r_uns && w_sbit) ? ~w_keep : '0);
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state: memory entries wait in REQ for ack or watchdog, then pass through DONE.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (bus.in_valid && w_is_mem) begin
`ifdef MEM_STAGE_MISALIGN_EN
          w_state_nxt = w_misalign ? DONE : REQ;
`else
          w_state_nxt = REQ;
`endif
        end
      end
      REQ:     if (bus.dmem_ack || w_timeout) w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Datapath: latch entry, drive the memory port, capture load data, raise MEM/WB valid and sticky err.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_size       <= '0;
      r_uns        <= 1'b0;
      r_is_load    <= 1'b0;
      r_off        <= '0;
      r_cnt        <= '0;
      r_dmem_req   <= 1'b0;
      r_dmem_we    <= 1'b0;
      r_dmem_addr  <= '0;
      r_dmem_wdata <= '0;
      r_dmem_be    <= '0;
      r_out_valid  <= 1'b0;
      r_out_rdata  <= '0;
      r_out_result <= '0;
      r_err        <= 1'b0;
    end else begin
      r_out_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.in_valid) begin
            r_out_result <= bus.result;
            r_out_rdata  <= '0;
            r_size       <= w_size;
            r_uns        <= bus.funct3[2];
            r_is_load    <= w_is_load;
            r_off        <= w_off;
            r_cnt        <= '0;
            if (!w_is_mem) begin
              r_out_valid <= 1'b1;
`ifdef MEM_STAGE_MISALIGN_EN
            end else if (w_misalign) begin
              r_err <= 1'b1;
`endif
            end else begin
              r_dmem_req   <= 1'b1;
              r_dmem_we    <= bus.mem_write;
              r_dmem_addr  <= w_addr;
              r_dmem_wdata <= w_wdata;
              r_dmem_be    <= w_be;
            end
          end
        end
        REQ: begin
          // An ack in the watchdog's final cycle still completes normally.
          if (bus.dmem_ack) begin
            r_dmem_req <= 1'b0;
            if (r_is_load) r_out_rdata <= w_ld;
          end else if (w_timeout) begin
            r_dmem_req <= 1'b0;
            r_err      <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        DONE:    r_out_valid <= 1'b1;
        default: r_out_valid <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Bench for mem_stage_ctrl: table of directed entries plus reset corner sequences.
// Latency: each entry is observed over a fixed 20-cycle window after it is driven.
// Backpressure: the bench plays the data memory and acks after a per-entry delay (or never).
module tb_mem_stage_ctrl;

`ifdef MEM_STAGE_MISALIGN_EN
  localparam bit MIS = 1'b1;
`else
  localparam bit MIS = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  mem_stage_ctrl_if #(.XLEN(32)) bus ();

  mem_stage_ctrl #(.XLEN(32), .TIMEOUT(8), .CNT_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL sim_timeout: got no end, expected finish");
    $fatal(1, "bench time limit");
  end

  typedef struct {
    bit        rd, wr, br, zr;
    bit [2:0]  f3;
    bit [31:0] res, wd, rdata;
    int        d;              // ack on this many cycles after req first seen; <0 never
    bit        bt;
    int        lat, irl, nreq; // out_valid cycle, in_ready-low cycles, req-high cycles
    bit        we;
    bit [31:0] addr, wdata;
    bit [3:0]  be;
    bit [31:0] ordata;
    bit        err;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int          nov    = 0;
    int          first  = -1;
    int          irl    = 0;
    int          nreq   = 0;
    bit          stable = 1'b1;
    logic [31:0] ord    = '0;
    logic [31:0] ores   = '0;
    logic        oerr   = 1'b0;
    @(negedge clk);
    bus.mem_read   = v.rd;
    bus.mem_write  = v.wr;
    bus.branch     = v.br;
    bus.zero       = v.zr;
    bus.funct3     = v.f3;
    bus.result     = v.res;
    bus.wd         = v.wd;
    bus.dmem_rdata = v.rdata;
    bus.dmem_ack   = 1'b0;
    bus.in_valid   = 1'b1;
    #1;
    chk($sformatf("v%0d_branch_taken", idx), 32'(bus.branch_taken), 32'(v.bt));
    chk($sformatf("v%0d_in_ready_accept", idx), 32'(bus.in_ready), 32'd1);
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
      if (bus.out_valid) begin
        nov++;
        if (first < 0) first = k;
        ord  = bus.out_rdata;
        ores = bus.out_result;
        oerr = bus.err;
      end
      if (!bus.in_ready) irl++;
      if (bus.dmem_req) begin
        nreq++;
        if (bus.dmem_addr !== v.addr || bus.dmem_be !== v.be) stable = 1'b0;
        if (nreq == 1) begin
          chk($sformatf("v%0d_dmem_we", idx), 32'(bus.dmem_we), 32'(v.we));
          chk($sformatf("v%0d_dmem_wdata", idx), bus.dmem_wdata, v.wdata);
        end
      end
      bus.dmem_ack = (v.d >= 0) && (k == 1 + v.d);
    end
    bus.dmem_ack = 1'b0;
    chk($sformatf("v%0d_out_valid_pulses", idx), 32'(nov), 32'd1);
    chk($sformatf("v%0d_latency", idx), 32'(first), 32'(v.lat));
    chk($sformatf("v%0d_in_ready_low", idx), 32'(irl), 32'(v.irl));
    chk($sformatf("v%0d_req_cycles", idx), 32'(nreq), 32'(v.nreq));
    if (v.nreq > 0) chk($sformatf("v%0d_addr_be_stable", idx), 32'(stable), 32'd1);
    chk($sformatf("v%0d_out_rdata", idx), ord, v.ordata);
    chk($sformatf("v%0d_out_result", idx), ores, v.res);
    chk($sformatf("v%0d_err", idx), 32'(oerr), 32'(v.err));
  endtask

  initial begin
    int nov;
    int nreq;
    //               rd wr br zr f3      res           wd            rdata         d   bt lat        irl        nreq       we addr          wdata         be       ordata                 err
    tbl.push_back('{0, 0, 1, 1, 3'b000, 32'h40,       32'h0,        32'h0,        -1, 1, 1,         0,         0,         0, 32'h0,        32'h0,        4'h0,    32'h0,                 0});
    tbl.push_back('{0, 0, 1, 0, 3'b000, 32'h123,      32'hFFFF,     32'h0,        -1, 0, 1,         0,         0,         0, 32'h0,        32'h0,        4'h0,    32'h0,                 0});
    tbl.push_back('{1, 0, 0, 0, 3'b000, 32'h1003,     32'h0,        32'h80FFFF12, 4,  0, 7,         6,         5,         0, 32'h1000,     32'h0,        4'b1000, 32'hFFFFFF80,          0});
    tbl.push_back('{1, 0, 0, 0, 3'b100, 32'h1003,     32'h0,        32'h80FFFF12, 0,  0, 3,         2,         1,         0, 32'h1000,     32'h0,        4'b1000, 32'h80,                0});
    tbl.push_back('{1, 0, 0, 0, 3'b101, 32'h2002,     32'h0,        32'hBEEF0000, 1,  0, 4,         3,         2,         0, 32'h2000,     32'h0,        4'b1100, 32'hBEEF,              0});
    tbl.push_back('{1, 0, 0, 0, 3'b001, 32'h2000,     32'h0,        32'h12348001, 2,  0, 5,         4,         3,         0, 32'h2000,     32'h0,        4'b0011, 32'hFFFF8001,          0});
    tbl.push_back('{0, 1, 0, 0, 3'b001, 32'h2002,     32'h1234,     32'h0,        0,  0, 3,         2,         1,         1, 32'h2000,     32'h12340000, 4'b1100, 32'h0,                 0});
    tbl.push_back('{0, 1, 0, 0, 3'b000, 32'h3001,     32'hA5,       32'h0,        1,  0, 4,         3,         2,         1, 32'h3000,     32'h0000A500, 4'b0010, 32'h0,                 0});
    tbl.push_back('{1, 0, 0, 0, 3'b010, 32'h1001,     32'h0,        32'hCAFEF00D, 0,  0, MIS ? 2 : 3, MIS ? 1 : 2, MIS ? 0 : 1, 0, 32'h1000, 32'h0,        4'hF,    MIS ? 32'h0 : 32'hCAFEF00D, MIS});
    tbl.push_back('{1, 1, 0, 0, 3'b010, 32'h4000,     32'hDEADBEEF, 32'h11111111, 0,  0, 3,         2,         1,         1, 32'h4000,     32'hDEADBEEF, 4'hF,    32'h0,                 MIS});
    tbl.push_back('{1, 0, 0, 0, 3'b010, 32'h5000,     32'h0,        32'h42,       7,  0, 10,        9,         8,         0, 32'h5000,     32'h0,        4'hF,    32'h42,                MIS});
    tbl.push_back('{1, 0, 0, 0, 3'b010, 32'h5004,     32'h0,        32'hFFFFFFFF, -1, 0, 10,        9,         8,         0, 32'h5004,     32'h0,        4'hF,    32'h0,                 1});
    tbl.push_back('{0, 0, 0, 1, 3'b000, 32'h77,       32'h0,        32'h0,        -1, 0, 1,         0,         0,         0, 32'h0,        32'h0,        4'h0,    32'h0,                 1});
    tbl.push_back('{1, 0, 1, 1, 3'b010, 32'h6004,     32'h0,        32'h7FFFFFFF, 0,  1, 3,         2,         1,         0, 32'h6004,     32'h0,        4'hF,    32'h7FFFFFFF,          1});

    rst_n          = 1'b0;
    bus.in_valid   = 1'b0;
    bus.mem_read   = 1'b0;
    bus.mem_write  = 1'b0;
    bus.branch     = 1'b0;
    bus.zero       = 1'b0;
    bus.funct3     = 3'b000;
    bus.result     = '0;
    bus.wd         = '0;
    bus.dmem_ack   = 1'b0;
    bus.dmem_rdata = '0;
    #2;
    chk("rst_dmem_req",   32'(bus.dmem_req),  32'd0);
    chk("rst_dmem_we",    32'(bus.dmem_we),   32'd0);
    chk("rst_dmem_addr",  bus.dmem_addr,      32'd0);
    chk("rst_dmem_wdata", bus.dmem_wdata,     32'd0);
    chk("rst_dmem_be",    32'(bus.dmem_be),   32'd0);
    chk("rst_out_valid",  32'(bus.out_valid), 32'd0);
    chk("rst_out_rdata",  bus.out_rdata,      32'd0);
    chk("rst_out_result", bus.out_result,     32'd0);
    chk("rst_err",        32'(bus.err),       32'd0);
    chk("rst_in_ready",   32'(bus.in_ready),  32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

    for (int i = 0; i < tbl.size(); i++) run_vec(tbl[i], i);

    // Reset while a load is outstanding, then a stray ack after release.
    @(negedge clk);
    bus.mem_read  = 1'b1;
    bus.mem_write = 1'b0;
    bus.branch    = 1'b0;
    bus.funct3    = 3'b010;
    bus.result    = 32'h7000;
    bus.in_valid  = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("midreq_req_before", 32'(bus.dmem_req), 32'd1);
    repeat (2) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midreq_req_dropped", 32'(bus.dmem_req), 32'd0);
    chk("midreq_err_cleared", 32'(bus.err), 32'd0);
    chk("midreq_in_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    bus.dmem_ack   = 1'b1;
    bus.dmem_rdata = 32'h5555_5555;
    nov  = 0;
    nreq = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      bus.dmem_ack = 1'b0;
      if (bus.out_valid) nov++;
      if (bus.dmem_req) nreq++;
    end
    chk("stray_ack_out_valid", 32'(nov), 32'd0);
    chk("stray_ack_req", 32'(nreq), 32'd0);
    chk("stray_ack_in_ready", 32'(bus.in_ready), 32'd1);
    chk("stray_ack_out_rdata", bus.out_rdata, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
